// File: rtl/rle_pkg.sv
// rle_pkg: RLE byte layout, run limits and compressor state encoding
// shared by the row compressor and decompressor.
package rle_pkg;
    localparam int RLE_VAL_BIT = 7;
    localparam int RUN_BITS    = 7;
    localparam int RUN_MAX     = (1 << RUN_BITS) - 1;

    typedef struct packed {
        logic       val;
        logic [6:0] run;
    } rle_byte_t;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} rle_cmp_state_t;
endpackage

// File: rtl/rle_compress_if.sv
// rle_compress_if: row input handshake, RLE byte output handshake and status.
// master is the environment side, slave is the compressor.
interface rle_compress_if #(parameter int WIDTH = 256);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_data;
    logic                     out_last;
    logic [$clog2(WIDTH):0]   byte_count;
    logic                     done;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, byte_count, done
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, byte_count, done
    );
endinterface

// File: rtl/rle_compress.sv
// rle_compress: scans a row MSB first, one bit per cycle, and emits
// {value, run} bytes; runs longer than RUN_MAX are split.
module rle_compress
    import rle_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    rle_compress_if.slave      bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    rle_cmp_state_t        r_state;
    logic [WIDTH-1:0]      r_row;
    logic                  r_cur_val;
    logic [RUN_BITS-1:0]   r_run;
    logic [CW-1:0]         r_bits_left;
    logic [CW-1:0]         r_byte_count;
    logic                  r_last;

    logic                  w_bit;
    logic                  w_extend;
    rle_byte_t             w_byte;

    assign w_bit    = r_row[WIDTH-1];
    assign w_extend = (w_bit == r_cur_val) && (r_run != RUN_BITS'(RUN_MAX));
    assign w_byte   = '{val: r_cur_val, run: r_run};

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = (r_state == EMIT);
    assign bus.out_data   = (r_state == EMIT) ? w_byte : '0;
    assign bus.out_last   = (r_state == EMIT) && r_last;
    assign bus.byte_count = r_byte_count;
    assign bus.done       = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_cur_val    <= 1'b0;
            r_run        <= '0;
            r_bits_left  <= '0;
            r_byte_count <= '0;
            r_last       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_row        <= bus.in_data;
                    r_cur_val    <= bus.in_data[WIDTH-1];
                    r_run        <= '0;
                    r_bits_left  <= CW'(WIDTH);
                    r_byte_count <= '0;
                    r_last       <= 1'b0;
                    r_state      <= SCAN;
                end
                // A value change or a full run leaves the bit in place for the next byte
                SCAN: if (w_extend) begin
                    r_run       <= r_run + 1'b1;
                    r_row       <= {r_row[WIDTH-2:0], 1'b0};
                    r_bits_left <= r_bits_left - 1'b1;
                    if (r_bits_left == CW'(1)) begin
                        r_last  <= 1'b1;
                        r_state <= EMIT;
                    end
                end else begin
                    r_last  <= 1'b0;
                    r_state <= EMIT;
                end
                EMIT: if (bus.out_ready) begin
                    r_byte_count <= r_byte_count + 1'b1;
                    if (r_last) begin
                        r_state <= DONE;
                    end else begin
                        r_cur_val <= w_bit;
                        r_run     <= '0;
                        r_state   <= SCAN;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
